// File: rtl/sr_drv_pkg.sv
// Shared types and sizing helper for the SR-latch pulse driver.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2
    } sr_drv_state_t;

    function automatic int cnt_width(input int pulse_cycles, input int guard_cycles);
        int longest;
        longest = (pulse_cycles > guard_cycles) ? pulse_cycles : guard_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter shared by the pulse and guard phases; saturates at zero.
// zero is combinational from the count register, so it reflects the current phase cycle.
module sr_drv_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Turns set/clear commands into timed s/r pulses plus a guard gap; one command in flight, no queueing.
// Optional SR_DRV_SKIP_REDUNDANT_EN drops commands that match the tracked latch value.
module sr_pulse_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_model,
    output logic q_known
);

    localparam int CW = cnt_width(PULSE_CYCLES, GUARD_CYCLES);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;

    sr_drv_state_t   state;
    sr_drv_state_t   state_nxt;
    logic            set_q;
    logic            set_nxt;
    logic            tmr_load;
    logic [CW-1:0]   tmr_value;
    logic            tmr_zero;
    logic            q_update;
    logic            s_nxt;
    logic            r_nxt;
    logic            redundant;

`ifdef SR_DRV_SKIP_REDUNDANT_EN
    assign redundant = q_known && (cmd_set == q_model);
`else
    assign redundant = 1'b0;
`endif

    sr_drv_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        set_nxt   = set_q;
        tmr_load  = 1'b0;
        tmr_value = PULSE_LOAD;
        q_update  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && !redundant) begin
                    state_nxt = PULSE;
                    set_nxt   = cmd_set;
                    tmr_load  = 1'b1;
                    tmr_value = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    q_update = 1'b1;
                    if (GUARD_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = GUARD;
                        tmr_load  = 1'b1;
                        tmr_value = GUARD_LOAD;
                    end
                end
            end
            GUARD: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // s and r are derived from one latched bit, so they can never be high together.
        s_nxt = (state_nxt == PULSE) && set_nxt;
        r_nxt = (state_nxt == PULSE) && !set_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            set_q   <= 1'b0;
            s       <= 1'b0;
            r       <= 1'b0;
            q_model <= 1'b0;
            q_known <= 1'b0;
        end else begin
            state <= state_nxt;
            set_q <= set_nxt;
            s     <= s_nxt;
            r     <= r_nxt;
            if (q_update) begin
                q_model <= set_q;
                q_known <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: default instance plus a PULSE_CYCLES=1/GUARD_CYCLES=0 instance on shared inputs.
module tb_sr_pulse_driver;

    localparam int PA = 4;
    localparam int GA = 2;
    localparam int PB = 1;
    localparam int GB = 0;
`ifdef SR_DRV_SKIP_REDUNDANT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid;
    logic cmd_set;
    logic a_ready, a_s, a_r, a_busy, a_q, a_known;
    logic b_ready, b_s, b_r, b_busy, b_q, b_known;

    always #5 clk = ~clk;

    sr_pulse_driver #(.PULSE_CYCLES(PA), .GUARD_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
        .cmd_ready(a_ready), .s(a_s), .r(a_r), .busy(a_busy), .q_model(a_q), .q_known(a_known)
    );

    sr_pulse_driver #(.PULSE_CYCLES(PB), .GUARD_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
        .cmd_ready(b_ready), .s(b_s), .r(b_r), .busy(b_busy), .q_model(b_q), .q_known(b_known)
    );

    // Model: the last accepted command (edge index k) plus the latch value committed before it.
    typedef struct { bit act; int k; bit set; bit q; bit known; } mdl_t;
    typedef struct { bit s; bit r; bit busy; bit ready; bit q; bit known; } want_t;
    typedef struct { bit v; bit st; bit s; bit r; bit rdy; bit busy; bit q; bit kn; } vec_t;

    mdl_t ma, mb;
    int   cyc;
    int   tests;
    int   fails;

    function automatic mdl_t m_clear();
        mdl_t m;
        m.act = 1'b0; m.k = 0; m.set = 1'b0; m.q = 1'b0; m.known = 1'b0;
        return m;
    endfunction

    // Period labelled n precedes edge n; the driver is idle once n > k + P + G.
    function automatic mdl_t m_edge(mdl_t m, int n, int p, int g, bit v, bit st);
        mdl_t o;
        bit   idle;
        o    = m;
        idle = !m.act || (n > m.k + p + g);
        if (v && idle) begin
            if (m.act) begin
                o.q     = m.set;
                o.known = 1'b1;
            end
            if (!(SKIP && o.known && (st == o.q))) begin
                o.act = 1'b1;
                o.k   = n;
                o.set = st;
            end
        end
        return o;
    endfunction

    function automatic want_t m_want(mdl_t m, int c, int p, int g);
        want_t w;
        bit pulse, guard, done;
        pulse   = m.act && (c >= m.k + 1) && (c <= m.k + p);
        guard   = m.act && (c >= m.k + p + 1) && (c <= m.k + p + g);
        done    = m.act && (c >= m.k + p + 1);
        w.s     = pulse && m.set;
        w.r     = pulse && !m.set;
        w.busy  = pulse || guard;
        w.ready = !(pulse || guard);
        w.q     = done ? m.set : m.q;
        w.known = done ? 1'b1 : m.known;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, got, want);
        end
    endtask

    task automatic cmp_dut(input string tag, input want_t w, input logic s_, input logic r_,
                           input logic busy_, input logic rdy_, input logic q_, input logic kn_);
        chk({tag, ".s"}, s_, w.s);
        chk({tag, ".r"}, r_, w.r);
        chk({tag, ".busy"}, busy_, w.busy);
        chk({tag, ".ready"}, rdy_, w.ready);
        chk({tag, ".q_model"}, q_, w.q);
        chk({tag, ".q_known"}, kn_, w.known);
        chk({tag, ".s_and_r"}, s_ && r_, 1'b0);
    endtask

    // Inputs are set at the falling edge before calling; outputs are checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            ma = m_edge(ma, cyc, PA, GA, cmd_valid, cmd_set);
            mb = m_edge(mb, cyc, PB, GB, cmd_valid, cmd_set);
        end
        @(negedge clk);
        cmp_dut("A", m_want(ma, cyc + 1, PA, GA), a_s, a_r, a_busy, a_ready, a_q, a_known);
        cmp_dut("B", m_want(mb, cyc + 1, PB, GB), b_s, b_r, b_busy, b_ready, b_q, b_known);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst.a_s", a_s, 1'b0);
        chk("rst.a_r", a_r, 1'b0);
        chk("rst.a_busy", a_busy, 1'b0);
        chk("rst.a_ready", a_ready, 1'b0);
        chk("rst.a_q_model", a_q, 1'b0);
        chk("rst.a_q_known", a_known, 1'b0);
        chk("rst.b_s", b_s, 1'b0);
        chk("rst.b_q_known", b_known, 1'b0);
        ma = m_clear();
        mb = m_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.a_ready_after", a_ready, 1'b1);
        chk("rst.b_ready_after", b_ready, 1'b1);
    endtask

    initial begin
        vec_t tbl [14];
        int   cnt_a, cnt_b, last_start, starts;
        logic prev;

        tests = 0; fails = 0; cyc = 0;
        cmd_valid = 1'b0; cmd_set = 1'b0;
        ma = m_clear(); mb = m_clear();

        // v, st | s, r, rdy, busy, q, kn  (outputs of the default instance after each edge)
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        do_reset();

        for (int i = 0; i < 14; i++) begin
            cmd_valid = tbl[i].v;
            cmd_set   = tbl[i].st;
            step();
            chk($sformatf("vec%0d.s", i), a_s, tbl[i].s);
            chk($sformatf("vec%0d.r", i), a_r, tbl[i].r);
            chk($sformatf("vec%0d.ready", i), a_ready, tbl[i].rdy);
            chk($sformatf("vec%0d.busy", i), a_busy, tbl[i].busy);
            chk($sformatf("vec%0d.q_model", i), a_q, tbl[i].q);
            chk($sformatf("vec%0d.q_known", i), a_known, tbl[i].kn);
        end

        // Set, then the same set again: skipped or a full second pulse depending on build.
        cmd_valid = 1'b1; cmd_set = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        cmd_valid = 1'b1; cmd_set = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("redundant.a_ready", a_ready, SKIP ? 1 : 0);
        cnt_a = int'(a_s);
        cnt_b = int'(b_s);
        for (int i = 0; i < 7; i++) begin
            step();
            cnt_a += int'(a_s);
            cnt_b += int'(b_s);
        end
        chk("redundant.a_pulse_len", cnt_a, SKIP ? 0 : PA);
        chk("redundant.b_pulse_len", cnt_b, SKIP ? 0 : PB);

        // Clear first so the following set is never redundant, then reset mid-pulse.
        cmd_valid = 1'b1; cmd_set = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        cmd_valid = 1'b1; cmd_set = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("midpulse.a_s_before_rst", a_s, 1'b1);
        do_reset();

        // Valid held high with cmd_set toggling every cycle: 7-cycle spacing alternates the command.
        cmd_valid  = 1'b1;
        last_start = -1;
        starts     = 0;
        prev       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cmd_set = ~cmd_set;
            step();
            if ((a_s || a_r) && !prev) begin
                if (last_start >= 0) chk("b2b.spacing", cyc - last_start, PA + GA + 1);
                last_start = cyc;
                starts++;
            end
            prev = a_s || a_r;
        end
        chk("b2b.enough_starts", starts >= 5, 1'b1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_set   = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Command-side driver for SR-latch storage cells. Accepts set/clear commands over a valid/ready handshake and converts each one into a clean, timed pulse on exactly one of `s` or `r`, followed by a guard interval. It guarantees that the forbidden `s = r = 1` input is never driven. It also keeps a model of the latch state it has written.

## Interface

Parameters:
- `PULSE_CYCLES`, default 4: cycles that `s` or `r` is held high per command; legal range is 1 or more.
- `GUARD_CYCLES`, default 2: cycles with `s = r = 0` after each pulse, before the next command is accepted; legal range is 0 or more.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: a command is presented.
- `cmd_set`, input, 1: 1 requests a set, 0 requests a clear. Meaningful only while `cmd_valid` is high.
- `cmd_ready`, output, 1: the driver can accept a command this cycle.
- `s`, output, 1: set drive to the latch. Registered.
- `r`, output, 1: reset drive to the latch. Registered.
- `busy`, output, 1: a pulse or guard interval is in progress.
- `q_model`, output, 1: latch value last written by the driver.
- `q_known`, output, 1: `q_model` is valid; at least one pulse has completed since reset.

## Operation

- The FSM has three states: IDLE, PULSE and GUARD.
- **IDLE**
  - `cmd_ready` = 1 and `s = r = 0`.
  - A handshake occurs when `cmd_valid && cmd_ready` is sampled high. The driver latches `cmd_set`, loads the counter with `PULSE_CYCLES-1` and moves to PULSE.
- **PULSE**
  - `s = latched_set` and `r = !latched_set`.
  - The counter decrements each cycle. At 0, `q_model` takes `latched_set` and `q_known` goes to 1.
  - Next state is GUARD with the counter loaded to `GUARD_CYCLES-1`, or IDLE directly if `GUARD_CYCLES == 0`.
- **GUARD**
  - `s = r = 0`.
  - The counter decrements; at 0 the FSM returns to IDLE.
- `cmd_ready = (state == IDLE)` and `busy = (state != IDLE)`.
- `cmd_valid` and `cmd_set` are ignored outside IDLE. There is no queueing.
- Invariant: `s && r` is never 1 in any cycle, including during and after reset.
- The counter width is `$clog2(max(PULSE_CYCLES, GUARD_CYCLES) + 1)`.

## Timing

- Reset values, applied asynchronously and immediately:
  - state = IDLE
  - `s = 0`, `r = 0`
  - `busy = 0`
  - `q_model = 0`, `q_known = 0`
  - `cmd_ready = 0` while `rst` is high, then 1 from the first cycle after deassertion.
- Command accepted at clock edge k:
  - `s` or `r` is high for cycles k+1 through k+`PULSE_CYCLES`.
  - Guard runs for the next `GUARD_CYCLES` cycles.
  - `cmd_ready` is high again in cycle k+`PULSE_CYCLES`+`GUARD_CYCLES`+1.
- Command-to-command throughput is `PULSE_CYCLES + GUARD_CYCLES + 1` cycles.
- `q_model` and `q_known` update in the same cycle that the pulse output falls, i.e. they are visible in the first GUARD cycle, or the first IDLE cycle if there is no guard.
- Reset mid-PULSE: the pulse is truncated at once, the command is lost and `q_known` is cleared. The latch state is treated as unknown.
- A `cmd_valid` held high continuously is re-accepted on every IDLE cycle. Each acceptance is one command.

## Configuration

The feature is controlled by the `SR_DRV_SKIP_REDUNDANT_EN` macro.

With the macro defined:
- In IDLE, a handshake where `q_known && cmd_set == q_model` completes without a pulse.
- The FSM stays in IDLE and `s` and `r` stay at 0.
- `cmd_ready` stays 1, so the next command can be accepted in the following cycle.

Without the macro:
- Every accepted command generates a full pulse and guard sequence, regardless of `q_model`.

## Structure

- Package `sr_drv_pkg` holds:
  - the state enum typedef `sr_drv_state_t` with values IDLE, PULSE and GUARD;
  - the counter-width helper function.
- Sub-module `sr_drv_timer`: a loadable down-counter with a `load`/`value` input and a `zero` flag output. It is instantiated once and shared by PULSE and GUARD.
- `sr_pulse_driver` contains the FSM, the output registers and the `q_model` tracking.

## Test plan

- **Reset.** Assert `rst` mid-PULSE of a set command → `s` drops in the same cycle, `q_known` = 0; after deassertion `cmd_ready` = 1 on the next cycle.
- **Single set.** With defaults, `cmd_set` = 1 is accepted at edge 10 → `s` = 1 for cycles 11–14, guard in cycles 15–16, `cmd_ready` = 1 at cycle 17, `q_model` = 1.
- **Back-to-back.** `cmd_valid` held high, alternating set/clear → pulses start 7 cycles apart; `s && r` is never 1 (checked by assertion every cycle).
- **Boundary parameters.** `PULSE_CYCLES` = 1, `GUARD_CYCLES` = 0 → 1-cycle pulses, next command accepted 2 cycles after the previous one.
- **Redundant command.** Set, then set again:
  - with `SR_DRV_SKIP_REDUNDANT_EN` defined → the second command produces no pulse and `cmd_ready` stays 1;
  - without the macro → a second 4-cycle `s` pulse.
- **Ignored input.** Toggle `cmd_valid`/`cmd_set` during PULSE → no effect on `s`/`r`; the latched command completes unchanged.
